// File: rtl/fix_tag_writer.sv
`default_nettype none
// ============================================================================
// Module      : fix_tag_writer
// Description : Parses a FIX "tag=value<SOH>" byte stream and writes each
//               field's left-aligned value word into the tag RAM at the
//               address given by the tag number. It also flags malformed
//               fields, drops out-of-range tags and marks tag 10
//               (the checksum) as end of message.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_tag_writer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_TAG_DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    output logic                  o_ram_cs,
    output logic                  o_ram_we,
    output logic                  o_ram_oe,
    output logic                  o_msg_done,
    output logic                  o_err,
    output logic                  o_drop,
    output logic                  o_trunc,
    output logic [15:0]           o_pair_count
);

    localparam int         c_BYTES  = DATA_WIDTH / 8;
    localparam int         c_TAG_W  = 17;
    localparam int         c_DCNT_W = $clog2(MAX_TAG_DIGITS + 1);
    localparam int         c_BCNT_W = $clog2(c_BYTES + 1);
    localparam logic [7:0] c_SOH    = 8'h01;
    localparam logic [7:0] c_EQ     = 8'h3D;

    typedef enum logic [1:0] {
        S_TAG   = 2'd0,
        S_VALUE = 2'd1,
        S_WRITE = 2'd2,
        S_SKIP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_TAG_W-1:0]    r_tag_acc;
    logic [c_DCNT_W-1:0]   r_digit_cnt;
    logic [DATA_WIDTH-1:0] r_value;
    logic [c_BCNT_W-1:0]   r_byte_cnt;
    logic                  r_trunc_pend;

    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_cs;
    logic                  r_ram_we;
    logic                  r_msg_done;
    logic                  r_err;
    logic                  r_drop;
    logic                  r_trunc;
    logic [15:0]           r_pair_count;

    logic                  w_accept;
    logic                  w_is_digit;
    logic                  w_is_soh;
    logic                  w_tag_in_range;
    logic [c_TAG_W-1:0]    w_tag_next;
    logic [DATA_WIDTH-1:0] w_value_next;

    assign w_accept       = i_in_valid && o_in_ready;
    assign w_is_digit     = (i_in_data >= 8'h30) && (i_in_data <= 8'h39);
    assign w_is_soh       = (i_in_data == c_SOH);
    // tag*10 + digit; 5 decimal digits never exceed 17 bits
    assign w_tag_next     = (r_tag_acc << 3) + (r_tag_acc << 1) + c_TAG_W'(i_in_data[3:0]);
    assign w_tag_in_range = ((r_tag_acc >> ADDR_WIDTH) == '0);

    // Drop the incoming value byte into its left-aligned slot in the word
    always_comb begin
        w_value_next = r_value;
        for (int i = 0; i < c_BYTES; i++) begin
            if (r_byte_cnt == c_BCNT_W'(i)) begin
                w_value_next[DATA_WIDTH-1-8*i -: 8] = i_in_data;
            end
        end
    end

    assign o_in_ready   = (r_state != S_WRITE);
    assign o_ram_oe     = 1'b0;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_ram_cs     = r_ram_cs;
    assign o_ram_we     = r_ram_we;
    assign o_msg_done   = r_msg_done;
    assign o_err        = r_err;
    assign o_drop       = r_drop;
    assign o_trunc      = r_trunc;
    assign o_pair_count = r_pair_count;

    // Field parser FSM with registered RAM-port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_TAG;
            r_tag_acc    <= '0;
            r_digit_cnt  <= '0;
            r_value      <= '0;
            r_byte_cnt   <= '0;
            r_trunc_pend <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_cs     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_msg_done   <= 1'b0;
            r_err        <= 1'b0;
            r_drop       <= 1'b0;
            r_trunc      <= 1'b0;
            r_pair_count <= '0;
        end else begin
            // pulses and the write strobe are single-cycle by default
            r_ram_cs   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_msg_done <= 1'b0;
            r_err      <= 1'b0;
            r_drop     <= 1'b0;
            r_trunc    <= 1'b0;

            case (r_state)
                S_TAG: begin
                    if (w_accept) begin
                        if (w_is_digit && (r_digit_cnt < c_DCNT_W'(MAX_TAG_DIGITS))) begin
                            r_tag_acc   <= w_tag_next;
                            r_digit_cnt <= r_digit_cnt + 1'b1;
                        end else if ((i_in_data == c_EQ) && (r_digit_cnt != '0)) begin
                            r_state <= S_VALUE;
                        end else begin
                            // malformed tag: flag it and discard to the next SOH
                            r_err       <= 1'b1;
                            r_state     <= S_SKIP;
                            r_tag_acc   <= '0;
                            r_digit_cnt <= '0;
                        end
                    end
                end

                S_VALUE: begin
                    if (w_accept) begin
                        if (w_is_soh) begin
                            if (w_tag_in_range) begin
                                r_state      <= S_WRITE;
                                r_ram_addr   <= r_tag_acc[ADDR_WIDTH-1:0];
                                r_ram_wdata  <= r_value;
                                r_ram_cs     <= 1'b1;
                                r_ram_we     <= 1'b1;
                                r_trunc      <= r_trunc_pend;
                                r_msg_done   <= (r_tag_acc == c_TAG_W'(10));
                                r_pair_count <= r_pair_count + 16'd1;
                            end else begin
                                r_drop       <= 1'b1;
                                r_state      <= S_TAG;
                                r_tag_acc    <= '0;
                                r_digit_cnt  <= '0;
                                r_value      <= '0;
                                r_byte_cnt   <= '0;
                                r_trunc_pend <= 1'b0;
                            end
                        end else if (r_byte_cnt < c_BCNT_W'(c_BYTES)) begin
                            r_value    <= w_value_next;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end else begin
                            r_trunc_pend <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    // write strobe is on the bus this cycle; reset for next field
                    r_state      <= S_TAG;
                    r_tag_acc    <= '0;
                    r_digit_cnt  <= '0;
                    r_value      <= '0;
                    r_byte_cnt   <= '0;
                    r_trunc_pend <= 1'b0;
                end

                S_SKIP: begin
                    if (w_accept && w_is_soh) begin
                        r_state <= S_TAG;
                    end
                end

                default: r_state <= S_TAG;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fix_tag_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fix_tag_writer
// Description : Directed self-checking bench for fix_tag_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_tag_writer;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        o_in_ready;
    logic [7:0]  o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic        o_ram_cs;
    logic        o_ram_we;
    logic        o_ram_oe;
    logic        o_msg_done;
    logic        o_err;
    logic        o_drop;
    logic        o_trunc;
    logic [15:0] o_pair_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_we   = 0;
    int n_rdy_low = 0;

    localparam logic [7:0] c_SOH = 8'h01;

    fix_tag_writer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_TAG_DIGITS(5)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .o_ram_cs     (o_ram_cs),
        .o_ram_we     (o_ram_we),
        .o_ram_oe     (o_ram_oe),
        .o_msg_done   (o_msg_done),
        .o_err        (o_err),
        .o_drop       (o_drop),
        .o_trunc      (o_trunc),
        .o_pair_count (o_pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes and not-ready cycles seen on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ram_we) n_we = n_we + 1;
            if (!o_in_ready) n_rdy_low = n_rdy_low + 1;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        i_in_valid = 1'b1;
        i_in_data  = b;
        while (!o_in_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck low, byte %h", b);
        end
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        n_cmp++; if ({o_ram_cs, o_ram_we, o_ram_oe} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {o_ram_cs, o_ram_we, o_ram_oe}); end
        n_cmp++; if ({o_msg_done, o_err, o_drop, o_trunc} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {o_msg_done, o_err, o_drop, o_trunc}); end
        n_cmp++; if ({o_ram_addr, o_ram_wdata, o_pair_count} !== 56'd0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h expected 0", o_ram_addr, o_ram_wdata, o_pair_count); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_in_ready); end
    endtask

    task automatic test_basic;
        send_str("35=D"); send(c_SOH);
        n_cmp++; if ({o_ram_cs, o_ram_we} !== 2'b11) begin n_fail++; $display("FAIL basic_we: got %b expected 11", {o_ram_cs, o_ram_we}); end
        n_cmp++; if (o_ram_addr !== 8'h23) begin n_fail++; $display("FAIL basic_addr: got %h expected 23", o_ram_addr); end
        n_cmp++; if (o_ram_wdata !== 32'h44000000) begin n_fail++; $display("FAIL basic_wdata: got %h expected 44000000", o_ram_wdata); end
        n_cmp++; if ({o_trunc, o_msg_done, o_err, o_drop, o_in_ready} !== 5'b00000) begin n_fail++; $display("FAIL basic_flags: got %b expected 00000", {o_trunc, o_msg_done, o_err, o_drop, o_in_ready}); end
        idle(2);
        n_cmp++; if ({o_ram_we, o_in_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_after: got %b expected 01", {o_ram_we, o_in_ready}); end
        n_cmp++; if (o_pair_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", o_pair_count); end
        n_cmp++; if (o_ram_wdata !== 32'h44000000) begin n_fail++; $display("FAIL basic_hold: got %h expected 44000000", o_ram_wdata); end
    endtask

    task automatic test_trunc;
        send_str("44=12345"); send(c_SOH);
        n_cmp++; if (o_ram_addr !== 8'h2C) begin n_fail++; $display("FAIL trunc_addr: got %h expected 2c", o_ram_addr); end
        n_cmp++; if (o_ram_wdata !== 32'h31323334) begin n_fail++; $display("FAIL trunc_wdata: got %h expected 31323334", o_ram_wdata); end
        n_cmp++; if ({o_ram_we, o_trunc} !== 2'b11) begin n_fail++; $display("FAIL trunc_pulse: got %b expected 11", {o_ram_we, o_trunc}); end
        idle(2);
        n_cmp++; if (o_pair_count !== 16'd2) begin n_fail++; $display("FAIL trunc_count: got %0d expected 2", o_pair_count); end
    endtask

    task automatic test_msg_done;
        send_str("10=123"); send(c_SOH);
        n_cmp++; if (o_ram_addr !== 8'h0A) begin n_fail++; $display("FAIL msg_addr: got %h expected 0a", o_ram_addr); end
        n_cmp++; if (o_ram_wdata !== 32'h31323300) begin n_fail++; $display("FAIL msg_wdata: got %h expected 31323300", o_ram_wdata); end
        n_cmp++; if ({o_ram_we, o_msg_done, o_trunc} !== 3'b110) begin n_fail++; $display("FAIL msg_pulse: got %b expected 110", {o_ram_we, o_msg_done, o_trunc}); end
        idle(2);
        n_cmp++; if (o_msg_done !== 1'b0) begin n_fail++; $display("FAIL msg_one_cycle: got %b expected 0", o_msg_done); end
    endtask

    task automatic test_back_to_back;
        int rdy0, we0;
        rdy0 = n_rdy_low;
        we0  = n_we;
        send_str("1=A"); send(c_SOH);
        n_cmp++; if ({o_ram_we, o_in_ready, o_ram_wdata} !== {2'b10, 32'h41000000}) begin n_fail++; $display("FAIL b2b_first: got %b %h expected 10 41000000", {o_ram_we, o_in_ready}, o_ram_wdata); end
        send_str("2=BC"); send(c_SOH);
        n_cmp++; if ({o_ram_addr, o_ram_wdata} !== {8'h02, 32'h42430000}) begin n_fail++; $display("FAIL b2b_second: got %h %h expected 02 42430000", o_ram_addr, o_ram_wdata); end
        idle(2);
        n_cmp++; if (n_rdy_low - rdy0 !== 2) begin n_fail++; $display("FAIL b2b_ready_low: got %0d expected 2", n_rdy_low - rdy0); end
        n_cmp++; if (n_we - we0 !== 2) begin n_fail++; $display("FAIL b2b_writes: got %0d expected 2", n_we - we0); end
        n_cmp++; if (o_pair_count !== 16'd5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", o_pair_count); end
    endtask

    task automatic test_error;
        int we0;
        we0 = n_we;
        send("3"); send("a");
        n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_bad_char: got %b expected 1", o_err); end
        send_str("=X"); send(c_SOH);
        n_cmp++; if ({o_ram_we, o_err} !== 2'b00) begin n_fail++; $display("FAIL err_skip_nowrite: got %b expected 00", {o_ram_we, o_err}); end
        send_str("49=Y"); send(c_SOH);
        n_cmp++; if ({o_ram_we, o_ram_addr, o_ram_wdata} !== {1'b1, 8'h31, 32'h59000000}) begin n_fail++; $display("FAIL err_recover: got %b %h %h expected 1 31 59000000", o_ram_we, o_ram_addr, o_ram_wdata); end
        send("=");
        n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_empty_tag: got %b expected 1", o_err); end
        send("5"); send(c_SOH);
        idle(2);
        n_cmp++; if (n_we - we0 !== 1) begin n_fail++; $display("FAIL err_writes: got %0d expected 1", n_we - we0); end
        n_cmp++; if (o_pair_count !== 16'd6) begin n_fail++; $display("FAIL err_count: got %0d expected 6", o_pair_count); end
    endtask

    task automatic test_drop;
        send_str("300=Z"); send(c_SOH);
        n_cmp++; if ({o_drop, o_ram_we, o_err} !== 3'b100) begin n_fail++; $display("FAIL drop_pulse: got %b expected 100", {o_drop, o_ram_we, o_err}); end
        send_str("12345");
        n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL drop_five_digits: got %b expected 0", o_err); end
        send("6");
        n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL drop_six_digits: got %b expected 1", o_err); end
        send_str("=1"); send(c_SOH);
        n_cmp++; if (o_ram_we !== 1'b0) begin n_fail++; $display("FAIL drop_no_write: got %b expected 0", o_ram_we); end
        idle(2);
        n_cmp++; if (o_pair_count !== 16'd6) begin n_fail++; $display("FAIL drop_count: got %0d expected 6", o_pair_count); end
        send_str("7="); send(c_SOH);
        n_cmp++; if ({o_ram_we, o_ram_addr, o_ram_wdata} !== {1'b1, 8'h07, 32'h0}) begin n_fail++; $display("FAIL empty_value: got %b %h %h expected 1 07 00000000", o_ram_we, o_ram_addr, o_ram_wdata); end
        idle(2);
    endtask

    task automatic test_reset_mid;
        send_str("55=AB");
        i_in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_cmp++; if ({o_ram_addr, o_ram_wdata, o_pair_count} !== 56'd0) begin n_fail++; $display("FAIL rstmid_regs: got %h %h %h expected 0", o_ram_addr, o_ram_wdata, o_pair_count); end
        n_cmp++; if ({o_ram_cs, o_ram_we, o_ram_oe, o_msg_done, o_err, o_drop, o_trunc, o_in_ready} !== 8'b00000001) begin n_fail++; $display("FAIL rstmid_ctrl: got %b expected 00000001", {o_ram_cs, o_ram_we, o_ram_oe, o_msg_done, o_err, o_drop, o_trunc, o_in_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_str("55=C"); send(c_SOH);
        n_cmp++; if ({o_ram_we, o_ram_addr, o_ram_wdata} !== {1'b1, 8'h37, 32'h43000000}) begin n_fail++; $display("FAIL rstmid_write: got %b %h %h expected 1 37 43000000", o_ram_we, o_ram_addr, o_ram_wdata); end
        idle(2);
        n_cmp++; if (o_pair_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 1", o_pair_count); end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_trunc;
        test_msg_done;
        test_back_to_back;
        test_error;
        test_drop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fix_tag_writer.md
# fix_tag_writer

Parses a FIX byte stream of `tag=value<SOH>` fields and writes each field's value word into the tag RAM, indexed by tag number. It sits directly upstream of the tag RAM, driving its port-0 write side. Downstream logic then reads parsed fields by tag through port 1. The block also flags malformed fields and marks end of message at the checksum tag (10).

## Interface
- ADDR_WIDTH, 8, tag RAM address width; tags ≥ 2^ADDR_WIDTH are dropped
- DATA_WIDTH, 32, tag RAM word width; must be a multiple of 8 (BYTES = DATA_WIDTH/8)
- MAX_TAG_DIGITS, 5, maximum decimal digits in a tag

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte (ASCII)
- in_ready  out  1  byte accepted when in_valid && in_ready
- ram_addr  out  ADDR_WIDTH  tag RAM address_0
- ram_wdata  out  DATA_WIDTH  value driven onto tag RAM data_0
- ram_cs  out  1  chip select_0
- ram_we  out  1  write enable_0
- ram_oe  out  1  output enable_0, constant 0
- msg_done  out  1  one-cycle pulse with the write of tag 10
- err  out  1  one-cycle pulse on a malformed field
- drop  out  1  one-cycle pulse when a well-formed field's tag is out of range
- trunc  out  1  one-cycle pulse with a write whose value exceeded BYTES bytes
- pair_count  out  16  count of completed RAM writes, wraps at 0xFFFF→0

## Operation
- **States:** TAG, VALUE, WRITE, SKIP. Reset state is TAG.
- **TAG**
  - Digit '0'–'9': tag_acc = tag_acc*10 + (byte−0x30), digit_cnt++.
  - '=' with digit_cnt ≥ 1: go to VALUE.
  - '=' with digit_cnt = 0, any non-digit, SOH, or a digit that would exceed MAX_TAG_DIGITS: err pulse, go to SKIP.
  - SOH arriving in TAG is therefore an error.
  - tag_acc is 17 bits and cannot overflow at 5 digits.
- **VALUE**
  - Any byte other than SOH (0x01) is value data, including '='.
  - Byte k (k = 0…BYTES−1) goes to value word bits [DATA_WIDTH−1−8k −: 8]. The word is left-aligned and zero-padded.
  - Bytes beyond BYTES are discarded and set the trunc_pending flag.
  - SOH with tag_acc < 2^ADDR_WIDTH: go to WRITE.
  - SOH with tag_acc out of range: drop pulse, no write, go to TAG.
  - Empty values (SOH immediately after '=') are legal and write 0.
- **WRITE** (exactly one cycle)
  - ram_cs=1, ram_we=1, ram_addr=tag_acc[ADDR_WIDTH-1:0], ram_wdata=value word.
  - trunc pulses if trunc_pending. msg_done pulses if tag_acc == 10.
  - pair_count increments. Accumulators clear. Go to TAG.
- **SKIP**
  - Discards bytes until SOH, then goes to TAG. No write occurs.
- **in_ready** = (state != WRITE), combinational from state.
- **Reset values:** all registered outputs reset to 0 (ram_addr, ram_wdata, ram_cs, ram_we, msg_done, err, drop, trunc, pair_count). in_ready = 1 after reset. ram_oe = 0 always.
- **Reset mid-field:** the partial field is discarded with no write, and the block restarts in TAG.

## Timing
- Outputs are registered. An SOH accepted in cycle N produces ram_cs/ram_we high in cycle N+1 only. The RAM captures the write at the end of N+1.
- in_ready is low in N+1 and high again in N+2, so the minimum field period is len+1 cycles.
- err asserts the cycle after the offending byte is accepted. drop asserts the cycle after the SOH.
- Bubbles (in_valid=0) hold all state. Outside WRITE, ram_cs/ram_we are 0 and ram_wdata holds its last value.

## Test plan
- Stream "35=D<SOH>" → one write: addr 0x23, wdata 0x44000000, pair_count 1, no pulses.
- Stream "44=12345<SOH>" → addr 0x2C, wdata 0x31323334, trunc=1 in the write cycle.
- Stream "10=123<SOH>" → addr 0x0A, wdata 0x31323300, msg_done=1 coincident with ram_we. Back-to-back fields with in_valid held high show in_ready low exactly one cycle per SOH.
- Stream "3a=X<SOH>49=Y<SOH>" → err pulse after 'a', no write for the first field, then addr 0x31 wdata 0x59000000. Also "=5<SOH>" → err.
- Stream "300=Z<SOH>" at ADDR_WIDTH=8 → drop pulse, no ram_we, pair_count unchanged. "123456=1<SOH>" → err on the 6th digit.
- Assert rst_n low mid-value in "55=AB…" → all outputs 0 and in_ready 1 during reset. Then "55=C<SOH>" → wdata 0x43000000, pair_count 1.
